// File: rtl/spi_storage_responder.sv
// Mode-0 SPI storage target serving 0x03 read / 0x02 write from an internal byte array.
// Optional SPI_RESP_STATUS_EN adds command 0x05, which returns the byte count of the last write.
module spi_storage_responder #(
    parameter int DEPTH       = 4096,
    parameter int ADDR_W      = $clog2(DEPTH),
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_cs_n,
    input  logic              spi_sck,
    input  logic              spi_mosi,
    output logic              spi_miso,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [7:0]        load_data,
    output logic              busy,
    output logic              cmd_error,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_READ   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_IGNORE = 3'd5,
        ST_STATUS = 3'd6
    } state_t;

    localparam int SR_W = (ADDR_W > 8) ? ADDR_W : 8;

    logic [SYNC_STAGES-1:0] cs_sync_q, sck_sync_q, mosi_sync_q;
    logic                   sck_d_q;
    logic                   cs_s, sck_s, mosi_s, rise, fall;

    state_t            state_q;
    logic [4:0]        bit_cnt_q;
    logic [SR_W-2:0]   shift_in_q;
    logic [SR_W-1:0]   shift_in_d;
    logic [7:0]        shift_out_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] addr_d;
    logic              is_read_q;
    logic              miso_q, busy_q, cmd_error_q;
    logic              spi_we;
`ifdef SPI_RESP_STATUS_EN
    logic [7:0]        wr_bytes_q, wr_count_q;
`endif

    logic [7:0] mem [DEPTH];

    // cs_n resets to its inactive level so a held-low pin cannot start a transaction mid-reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cs_sync_q   <= {SYNC_STAGES{1'b1}};
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
            sck_d_q     <= 1'b0;
        end else begin
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            sck_d_q     <= sck_s;
        end
    end

    assign cs_s       = cs_sync_q[SYNC_STAGES-1];
    assign sck_s      = sck_sync_q[SYNC_STAGES-1];
    assign mosi_s     = mosi_sync_q[SYNC_STAGES-1];
    assign rise       = sck_s & ~sck_d_q;
    assign fall       = ~sck_s & sck_d_q;
    assign shift_in_d = {shift_in_q, mosi_s};
    assign addr_d     = shift_in_d[ADDR_W-1:0];
    assign spi_we     = (state_q == ST_WRITE) && !cs_s && rise && (bit_cnt_q == 5'd7);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_in_q  <= '0;
            shift_out_q <= '0;
            ptr_q       <= '0;
            is_read_q   <= 1'b0;
            miso_q      <= 1'b0;
            busy_q      <= 1'b0;
            cmd_error_q <= 1'b0;
`ifdef SPI_RESP_STATUS_EN
            wr_bytes_q  <= '0;
            wr_count_q  <= '0;
`endif
        end else begin
            busy_q      <= ~cs_s;
            cmd_error_q <= 1'b0;
            if (cs_s) begin
`ifdef SPI_RESP_STATUS_EN
                if (state_q == ST_WRITE) wr_count_q <= wr_bytes_q;
`endif
                state_q    <= ST_IDLE;
                bit_cnt_q  <= '0;
                shift_in_q <= '0;
                miso_q     <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q   <= ST_CMD;
                        bit_cnt_q <= '0;
                    end
                    ST_CMD: if (rise) begin
                        shift_in_q <= shift_in_d[SR_W-2:0];
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_q <= '0;
                            case (shift_in_d[7:0])
                                8'h03: begin is_read_q <= 1'b1; state_q <= ST_ADDR; end
                                8'h02: begin is_read_q <= 1'b0; state_q <= ST_ADDR; end
`ifdef SPI_RESP_STATUS_EN
                                8'h05: begin
                                    shift_out_q <= wr_count_q;
                                    state_q     <= ST_STATUS;
                                end
`endif
                                default: begin
                                    cmd_error_q <= 1'b1;
                                    state_q     <= ST_IGNORE;
                                end
                            endcase
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                        end
                    end
                    ST_ADDR: if (rise) begin
                        shift_in_q <= shift_in_d[SR_W-2:0];
                        if (bit_cnt_q == 5'd23) begin
                            bit_cnt_q <= '0;
                            if (is_read_q) begin
                                shift_out_q <= mem[addr_d];
                                ptr_q       <= addr_d + ADDR_W'(1);
                                state_q     <= ST_READ;
                            end else begin
                                ptr_q   <= addr_d;
                                state_q <= ST_WRITE;
`ifdef SPI_RESP_STATUS_EN
                                wr_bytes_q <= '0;
`endif
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                        end
                    end
                    // The 8th fall drives bit 0 and pre-loads the next byte in the same cycle
                    ST_READ: if (fall) begin
                        miso_q <= shift_out_q[7];
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_q   <= '0;
                            shift_out_q <= mem[ptr_q];
                            ptr_q       <= ptr_q + ADDR_W'(1);
                        end else begin
                            bit_cnt_q   <= bit_cnt_q + 5'd1;
                            shift_out_q <= {shift_out_q[6:0], 1'b0};
                        end
                    end
                    ST_WRITE: if (rise) begin
                        shift_in_q <= shift_in_d[SR_W-2:0];
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_q <= '0;
                            ptr_q     <= ptr_q + ADDR_W'(1);
`ifdef SPI_RESP_STATUS_EN
                            if (wr_bytes_q != 8'hFF) wr_bytes_q <= wr_bytes_q + 8'd1;
`endif
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                        end
                    end
                    ST_IGNORE: begin
                        miso_q <= 1'b0;
                    end
`ifdef SPI_RESP_STATUS_EN
                    ST_STATUS: if (fall) begin
                        miso_q <= shift_out_q[7];
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_q   <= '0;
                            shift_out_q <= wr_count_q;
                        end else begin
                            bit_cnt_q   <= bit_cnt_q + 5'd1;
                            shift_out_q <= {shift_out_q[6:0], 1'b0};
                        end
                    end
`endif
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    // Array is deliberately not reset; the SPI write is issued last so it wins a same-address clash
    always_ff @(posedge clk) begin
        if (load_en) mem[load_addr] <= load_data;
        if (spi_we)  mem[ptr_q]     <= shift_in_d[7:0];
    end

    assign spi_miso  = miso_q;
    assign busy      = busy_q;
    assign cmd_error = cmd_error_q;
    assign state_dbg = state_q;

endmodule

// File: doc/spi_storage_responder.md
Name: spi_storage_responder

Overview:
SPI target (mode 0, MSB first) that acts as the far end of the storage controller's external-storage SPI master. It decodes read/write commands and serves them from an internal byte array. It is used as the synthesizable external-storage model in controller benches and FPGA bring-up. SPI inputs are oversampled in the system clock domain, so no SCK-clocked logic is involved.

Parameters:
DEPTH, 4096, byte capacity of the internal array; must be a power of 2, minimum 16
ADDR_W, $clog2(DEPTH), number of low address bits used to index the array
SYNC_STAGES, 2, synchronizer flops on spi_cs_n, spi_sck and spi_mosi; minimum 2

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
spi_cs_n  in  1  chip select, active low
spi_sck  in  1  SPI clock, idle low
spi_mosi  in  1  data from the master
spi_miso  out  1  data to the master
load_en  in  1  backdoor byte write strobe
load_addr  in  ADDR_W  backdoor write address
load_data  in  8  backdoor write data
busy  out  1  high while cs_n is low (synchronized view)
cmd_error  out  1  one-cycle pulse when an unknown command byte completes

Behaviour:
- Reset (rst=0, asynchronous): spi_miso=0, busy=0, cmd_error=0, state=IDLE, all counters and shift registers cleared. Array contents are undefined and not cleared.
- Input synchronizers: SYNC_STAGES flops on each SPI input, then one extra flop on sck for edge detection. rise = sck_s & ~sck_d; fall = ~sck_s & sck_d.
- Timing requirement: each SCK half-period must be at least 4 clk cycles. The response lag is SYNC_STAGES+1 clk cycles from a pin edge.
- States: IDLE, CMD, ADDR, READ, WRITE, IGNORE.
  - IDLE -> CMD on synchronized cs_n falling.
  - CMD: shift mosi on each rise. At the 8th rise, decode: 0x03 -> ADDR (read), 0x02 -> ADDR (write). Any other value pulses cmd_error and goes to IGNORE.
  - ADDR: shift 24 bits, MSB first. At the 24th rise, latch ptr = addr[ADDR_W-1:0] and go to READ or WRITE.
  - READ: on entry, load shift_out = mem[ptr] and increment ptr. On each fall, drive spi_miso = shift_out[7] and shift left. After 8 falls, reload from mem[ptr] and increment ptr.
  - WRITE: shift mosi on each rise. At every 8th rise, write mem[ptr] and increment ptr.
  - IGNORE: consume clocks, no effect.
- Any state -> IDLE on synchronized cs_n high. This takes effect the cycle it is seen: bit counters are cleared and spi_miso is forced to 0. A partially received write byte is discarded and not written.
- Pointer wraps modulo DEPTH; address 0xFFF + 1 becomes 0x000 for DEPTH=4096.
- spi_miso is 0 in IDLE, CMD, ADDR, WRITE and IGNORE. It is not tristated.
- spi_sck edges while cs_n is high are ignored.
- Backdoor port: load_en writes load_data to mem[load_addr] in the same cycle.
  - Allowed at any time.
  - If an SPI byte write and load_en hit the same address in the same cycle, the SPI write wins.
  - Read data is sampled at byte-load time, so later backdoor writes do not affect a byte already being shifted out.
- busy mirrors ~cs_n_synchronized, registered.

Optional Feature:
SPI_RESP_STATUS_EN
- Defined:
  - Command 0x05 is legal and goes to a STATUS state. STATUS shifts out wr_count, an 8-bit count of bytes committed by the most recent completed write transaction, saturating at 0xFF.
  - The status byte repeats every 8 falls until cs_n rises.
  - wr_count is reset to 0 and updated when a WRITE transaction ends.
- Undefined:
  - 0x05 is an unknown command: cmd_error pulses and the state goes to IGNORE.
  - No wr_count register exists.

Test Plan:
- Reset mid-read: assert rst low during the READ data phase -> spi_miso=0, busy=0 immediately. A following 0x03 read from address 0 returns the preloaded byte correctly.
- Backdoor + read: load 0xA5 at 0x010 and 0x3C at 0x011, then send 0x03 with address 0x000010 and clock 16 bits -> MISO returns 0xA5 then 0x3C.
- Write then read: send 0x02 with address 0x000FFE and data 0x11, 0x22, 0x33 -> mem[0xFFE]=0x11, mem[0xFFF]=0x22, mem[0x000]=0x33 (wrap). Read-back at 0xFFE returns 0x11 0x22 0x33.
- Abort: send 0x02 with address 0x000020 and data 0x77, then 5 bits of 0xFF, then cs_n high -> mem[0x020]=0x77 and mem[0x021] unchanged. busy drops within SYNC_STAGES+2 cycles.
- Unknown command 0x9F -> exactly one cmd_error pulse, MISO held 0 for the next 32 SCK cycles, array unchanged.
- With SPI_RESP_STATUS_EN: write 3 bytes, then send 0x05 -> MISO returns 0x03, 0x03. Without the macro, 0x05 -> cmd_error pulse.
